// File: rtl/branch_sequencer.sv
// ----------------------------------------------------------------------------
// branch_sequencer
//   PC sequencer with a four-state conditional-branch handshake against an
//   external condition (CON) flip-flop.
//
//   A branch accepted in IDLE walks IDLE -> EVAL -> SAMPLE -> UPDATE -> IDLE:
//     EVAL   : con_enable is high so the CON FF evaluates.
//     SAMPLE : con_in is registered at the end of this cycle.
//     UPDATE : pc <= captured_pc + sext(offset) if the condition was true;
//              br_done pulses and br_taken updates on the edge leaving UPDATE.
//   Outside a branch, pc_inc in IDLE advances pc by one. pc_ld overrides
//   everything in any state and abandons an in-flight branch.
//
// Optional build macro: BRANCH_STATS_EN adds saturating taken/not-taken
//   counters (taken_cnt, nottaken_cnt).
//
// Parameters
//   RESET_PC  : pc value on reset
//   OFF_W     : branch offset width (signed word offset)
// Ports
//   clk          in   rising-edge clock
//   clr          in   asynchronous active-high reset
//   pc_inc       in   fetch increment request (IDLE only)
//   pc_ld        in   unconditional pc load strobe, highest priority
//   pc_ld_val    in   value loaded by pc_ld
//   br_req       in   branch request (valid)
//   br_offset    in   signed offset, sampled on acceptance
//   br_ready     out  high in IDLE; accept = br_req & br_ready
//   con_enable   out  evaluate strobe to CON FF (EVAL only)
//   con_in       in   condition result from CON FF
//   pc           out  current program counter
//   br_done      out  one-cycle branch completion pulse
//   br_taken     out  result of last completed branch
//   taken_cnt    out  (BRANCH_STATS_EN) taken branch count, saturating
//   nottaken_cnt out  (BRANCH_STATS_EN) not-taken branch count, saturating
// ----------------------------------------------------------------------------
module branch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          OFF_W    = 19
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pc_inc,
    input  logic             pc_ld,
    input  logic [31:0]      pc_ld_val,
    input  logic             br_req,
    input  logic [OFF_W-1:0] br_offset,
    output logic             br_ready,
    output logic             con_enable,
    input  logic             con_in,
    output logic [31:0]      pc,
    output logic             br_done,
`ifdef BRANCH_STATS_EN
    output logic             br_taken,
    output logic [15:0]      taken_cnt,
    output logic [15:0]      nottaken_cnt
`else
    output logic             br_taken
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        SAMPLE = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t           state;
    logic [OFF_W-1:0] off_q;   // offset captured at acceptance
    logic [31:0]      pc_q;    // pc captured at acceptance
    logic             cond_q;  // condition sampled at end of SAMPLE
    logic [31:0]      off_ext;

    // Sign-extend the word offset; the add below wraps mod 2^32.
    assign off_ext  = {{(32-OFF_W){off_q[OFF_W-1]}}, off_q};
    assign br_ready = (state == IDLE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            off_q        <= '0;
            pc_q         <= '0;
            cond_q       <= 1'b0;
            con_enable   <= 1'b0;
            br_done      <= 1'b0;
            br_taken     <= 1'b0;
`ifdef BRANCH_STATS_EN
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
`endif
        end else if (pc_ld) begin
            // Load wins in every state and drops any in-flight branch;
            // br_taken and the stats counters keep their values.
            pc         <= pc_ld_val;
            state      <= IDLE;
            con_enable <= 1'b0;
            br_done    <= 1'b0;
        end else begin
            con_enable <= 1'b0;
            br_done    <= 1'b0;
            case (state)
                IDLE: begin
                    // A request takes priority; a same-cycle pc_inc is dropped.
                    if (br_req) begin
                        off_q      <= br_offset;
                        pc_q       <= pc;
                        state      <= EVAL;
                        con_enable <= 1'b1;
                    end else if (pc_inc) begin
                        pc <= pc + 32'd1;
                    end
                end
                EVAL: begin
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    cond_q <= con_in;
                    state  <= UPDATE;
                end
                UPDATE: begin
                    if (cond_q) pc <= pc_q + off_ext;
                    br_done  <= 1'b1;
                    br_taken <= cond_q;
                    state    <= IDLE;
`ifdef BRANCH_STATS_EN
                    if (cond_q) begin
                        if (taken_cnt != 16'hFFFF) taken_cnt <= taken_cnt + 16'd1;
                    end else begin
                        if (nottaken_cnt != 16'hFFFF) nottaken_cnt <= nottaken_cnt + 16'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_branch_sequencer
//   Directed self-checking bench for branch_sequencer (RESET_PC = 32'h100).
//   Inputs change 1 ns after each rising edge; outputs are sampled there too,
//   well clear of the next active edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_sequencer;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        clr;
    logic        pc_inc;
    logic        pc_ld;
    logic [31:0] pc_ld_val;
    logic        br_req;
    logic [18:0] br_offset;
    logic        br_ready;
    logic        con_enable;
    logic        con_in;
    logic [31:0] pc;
    logic        br_done;
    logic        br_taken;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] nottaken_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    branch_sequencer #(.RESET_PC(RPC), .OFF_W(19)) dut (
        .clk          (clk),
        .clr          (clr),
        .pc_inc       (pc_inc),
        .pc_ld        (pc_ld),
        .pc_ld_val    (pc_ld_val),
        .br_req       (br_req),
        .br_offset    (br_offset),
        .br_ready     (br_ready),
        .con_enable   (con_enable),
        .con_in       (con_in),
        .pc           (pc),
        .br_done      (br_done),
`ifdef BRANCH_STATS_EN
        .br_taken     (br_taken),
        .taken_cnt    (taken_cnt),
        .nottaken_cnt (nottaken_cnt)
`else
        .br_taken     (br_taken)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_ld = 1'b1; pc_ld_val = v;
        tick();
        pc_ld = 1'b0; pc_ld_val = '0;
        chk("load_pc", pc, v);
    endtask

    // One full branch from IDLE. con_in is driven to the opposite value
    // outside SAMPLE so a DUT sampling in the wrong state is caught.
    task automatic run_branch(input string tag, input logic [18:0] off, input logic cond,
                              input logic [31:0] pc_before);
        br_offset = off; br_req = 1'b1;
        tick();                                   // acceptance edge -> EVAL
        br_req = 1'b0; br_offset = 19'h2AAAA;     // offset must already be captured
        chk({tag, " eval con_enable"}, 32'(con_enable), 32'd1);
        chk({tag, " eval br_ready"},   32'(br_ready),   32'd0);
        con_in = ~cond;
        tick();                                   // -> SAMPLE
        chk({tag, " sample con_enable"}, 32'(con_enable), 32'd0);
        con_in = cond;
        tick();                                   // -> UPDATE
        con_in = ~cond;
        chk({tag, " update br_done"}, 32'(br_done), 32'd0);
        chk({tag, " update pc"},      pc,           pc_before);
        tick();                                   // -> IDLE, completion
        con_in = 1'b0;
        chk({tag, " br_done"},  32'(br_done),  32'd1);
        chk({tag, " br_taken"}, 32'(br_taken), 32'(cond));
        chk({tag, " br_ready"}, 32'(br_ready), 32'd1);
        tick();
        chk({tag, " br_done low"}, 32'(br_done), 32'd0);
    endtask

    initial begin
        clr = 1'b1; pc_inc = 1'b0; pc_ld = 1'b0; pc_ld_val = '0;
        br_req = 1'b0; br_offset = '0; con_in = 1'b0;
        #12;
        chk("rst pc",         pc,               RPC);
        chk("rst br_done",    32'(br_done),     32'd0);
        chk("rst br_taken",   32'(br_taken),    32'd0);
        chk("rst con_enable", 32'(con_enable),  32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        tick();
        chk("post-rst br_ready", 32'(br_ready), 32'd1);

        // three increments
        pc_inc = 1'b1;
        repeat (3) tick();
        pc_inc = 1'b0;
        tick();
        chk("inc pc", pc, 32'h103);
        chk("inc br_ready", 32'(br_ready), 32'd1);

        // taken, positive offset
        load_pc(32'h200);
        run_branch("b+16", 19'h00010, 1'b1, 32'h200);
        chk("b+16 pc", pc, 32'h210);

        // offset -1 not taken, then taken
        load_pc(32'h200);
        run_branch("b-1 nt", 19'h7FFFF, 1'b0, 32'h200);
        chk("b-1 nt pc", pc, 32'h200);
        run_branch("b-1 t", 19'h7FFFF, 1'b1, 32'h200);
        chk("b-1 t pc", pc, 32'h1FF);

        // wrap-around
        load_pc(32'hFFFF_FFFE);
        run_branch("wrap", 19'h00004, 1'b1, 32'hFFFF_FFFE);
        chk("wrap pc", pc, 32'h0000_0002);

        // br_req beats pc_inc; pc_ld in SAMPLE abandons the branch
        load_pc(32'h300);
        br_req = 1'b1; pc_inc = 1'b1; br_offset = 19'h00020; con_in = 1'b1;
        tick();
        br_req = 1'b0; pc_inc = 1'b0;
        chk("prio pc", pc, 32'h300);
        chk("prio con_enable", 32'(con_enable), 32'd1);
        tick();                                   // SAMPLE
        pc_ld = 1'b1; pc_ld_val = 32'h500;
        tick();
        pc_ld = 1'b0; pc_ld_val = '0;
        chk("ld pc", pc, 32'h500);
        chk("ld br_done", 32'(br_done), 32'd0);
        chk("ld br_ready", 32'(br_ready), 32'd1);
        chk("ld br_taken kept", 32'(br_taken), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ld no late done", 32'(br_done), 32'd0);
        end
        chk("ld pc held", pc, 32'h500);
        con_in = 1'b0;

        // back-to-back with br_req held; pc_inc held is ignored throughout
        load_pc(32'h0);
        br_req = 1'b1; br_offset = 19'h00001; con_in = 1'b1; pc_inc = 1'b1;
        tick();                                   // first acceptance
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk($sformatf("b2b done@%0d", i), 32'(br_done), (i == 3 || i == 7) ? 32'd1 : 32'd0);
        end
        br_req = 1'b0; pc_inc = 1'b0; con_in = 1'b0;
        chk("b2b pc", pc, 32'h2);

`ifdef BRANCH_STATS_EN
        clr = 1'b1; #2; clr = 1'b0;
        tick();
        chk("st rst taken", 32'(taken_cnt), 32'd0);
        run_branch("st t1",  19'h1, 1'b1, RPC);
        run_branch("st n1",  19'h1, 1'b0, RPC + 32'd1);
        run_branch("st t2",  19'h1, 1'b1, RPC + 32'd1);
        run_branch("st n2",  19'h1, 1'b0, RPC + 32'd2);
        load_pc(32'h40);
        run_branch("st n3",  19'h1, 1'b0, 32'h40);
        chk("st taken_cnt",    32'(taken_cnt),    32'd2);
        chk("st nottaken_cnt", 32'(nottaken_cnt), 32'd3);
`endif

        // clr during EVAL: branch abandoned
        load_pc(32'h700);
        br_req = 1'b1; br_offset = 19'h00008; con_in = 1'b1;
        tick();
        br_req = 1'b0;
        chk("clr in eval", 32'(con_enable), 32'd1);
        clr = 1'b1;
        #1;
        chk("clr pc",         pc,              RPC);
        chk("clr con_enable", 32'(con_enable), 32'd0);
        chk("clr br_ready",   32'(br_ready),   32'd1);
`ifdef BRANCH_STATS_EN
        chk("clr taken_cnt",    32'(taken_cnt),    32'd0);
        chk("clr nottaken_cnt", 32'(nottaken_cnt), 32'd0);
`endif
        tick();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("clr no done", 32'(br_done), 32'd0);
        end
        chk("clr pc held", pc, RPC);
        con_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
